// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;
  // Latency counter width; holds 0..6 for ROM_LATENCY up to 7.
  localparam int CNT_W = 3;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// ROM read port: the fetch unit drives enable/address, the ROM returns data.
interface fetch_rom_if;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  modport master (output rom_en, output rom_addr, input rom_data);
  modport slave  (input rom_en, input rom_addr, output rom_data);
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register; priority is reset > redirect > step on issue > hold.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        write_pc,
  input  logic [31:0] pc_new,
  input  logic        inc,
  output logic [31:0] pc
);
  always_ff @(posedge clk) begin
    if (Rst)           pc <= RESET_PC;
    else if (write_pc) pc <= pc_new;
    else if (inc)      pc <= pc + PC_STEP;
  end
endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch sequencer: IDLE -> REQ -> WAIT (ROM_LATENCY cycles) -> ISSUE.
// Optional misaligned-PC trap is enabled with `define FETCH_ALIGN_CHECK_EN.
// ROM handshake: rom_en is a one-cycle registered request; rom_data is valid
// exactly ROM_LATENCY cycles later, with no back-pressure from the ROM.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          ROM_LATENCY = 1,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic         fetch_req,
  input  logic         Write_PC,
  input  logic [31:0]  PC_New,
  fetch_rom_if.master  rom,
  output logic [31:0]  PC,
  output logic [31:0]  Inst,
  output logic         Write_IR,
  output logic         busy,
  output logic         fetch_fault,
  output fetch_state_t state_dbg
);
  fetch_state_t     state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             last_wait;
  logic             fault_now;
  logic             rom_en_d;
  logic             rom_en_q;
  logic [31:0]      rom_addr_q;
  logic [31:0]      pc_target;

  // Address the next request will use: a redirect in this cycle takes effect now.
  assign pc_target = Write_PC ? PC_New : PC;
  assign last_wait = (state == WAIT) && (cnt == CNT_W'(ROM_LATENCY - 1));

`ifdef FETCH_ALIGN_CHECK_EN
  assign fault_now = (state == REQ) && (PC[1:0] != 2'b00) && !Write_PC;
  assign rom_en_d  = (state_next == REQ) && (pc_target[1:0] == 2'b00);
`else
  assign fault_now = 1'b0;
  assign rom_en_d  = (state_next == REQ);
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_req) state_next = REQ;
      REQ: begin
        if (Write_PC)       state_next = REQ;
        else if (fault_now) state_next = IDLE;
        else                state_next = WAIT;
      end
      WAIT: begin
        if (Write_PC)       state_next = REQ;
        else if (last_wait) state_next = ISSUE;
      end
      ISSUE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state      <= IDLE;
      cnt        <= '0;
      Inst       <= 32'h0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= RESET_PC & ~32'h3;
    end else begin
      state    <= state_next;
      rom_en_q <= rom_en_d;
      if (state_next == REQ) rom_addr_q <= pc_target & ~32'h3;
      cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
      // An abandoned fetch never reaches Inst.
      if (last_wait && !Write_PC) Inst <= rom.rom_data;
    end
  end

  fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk      (clk),
    .Rst      (Rst),
    .write_pc (Write_PC),
    .pc_new   (PC_New),
    .inc      (state == ISSUE),
    .pc       (PC)
  );

  assign rom.rom_en   = rom_en_q;
  assign rom.rom_addr = rom_addr_q;
  assign Write_IR     = (state == ISSUE);
  assign busy         = (state != IDLE);
  assign fetch_fault  = fault_now;
  assign state_dbg    = state;
endmodule
